ras_ckpt: RTL

RAS_CKPT -- requirements
Module: ras_ckpt

---
 rtl/ras_ckpt.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ras_ckpt.sv
// ras_ckpt -- return-address stack with a single pointer/count checkpoint.
//
// A circular buffer of DEPTH return addresses. Calls push, returns pop, and a
// push into a full stack silently evicts the oldest entry. A checkpoint of the
// top pointer and entry count can be saved and later restored so that
// speculative call/return activity can be rolled back. Entry contents are not
// checkpointed, only the pointer and count.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   rst_ni         synchronous active-low reset
//   flush_i        empty the stack and clear the checkpoint
//   push_i         push data_i (call)
//   pop_i          pop the top entry (return)
//   data_i         return address to push
//   ckpt_save_i    snapshot top pointer and count
//   ckpt_restore_i reload top pointer and count from the snapshot
//   data_o         top-of-stack address, zero when empty
//   valid_o        stack non-empty
//   count_o        number of valid entries, 0..DEPTH
//   overflow_o     one-cycle pulse: a push evicted the oldest entry
//   underflow_o    one-cycle pulse: a pop was issued on an empty stack

module ras_ckpt #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [XLEN-1:0]          data_i,
    input  logic                     ckpt_save_i,
    input  logic                     ckpt_restore_i,
    output logic [XLEN-1:0]          data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   tp;
    logic [PW-1:0]   saved_tp;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   saved_cnt;
    logic            overflow;
    logic            underflow;

    logic [PW-1:0]   tp_inc;
    logic [PW-1:0]   tp_dec;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign tp_inc = tp + PW'(1);
    assign tp_dec = tp - PW'(1);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tp        <= '0;
            cnt       <= '0;
            saved_tp  <= '0;
            saved_cnt <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            // Entries are left in place; only the bookkeeping is cleared.
            tp        <= '0;
            cnt       <= '0;
            saved_tp  <= '0;
            saved_cnt <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (ckpt_restore_i) begin
            // A save in the same cycle is dropped, as are push/pop.
            tp        <= saved_tp;
            cnt       <= saved_cnt;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;

            // Snapshot uses the pre-edge values even when a push/pop
            // happens in the same cycle.
            if (ckpt_save_i) begin
                saved_tp  <= tp;
                saved_cnt <= cnt;
            end

            if (push_i && pop_i) begin
                // Return immediately followed by a call: replace the top.
                mem[tp] <= data_i;
                if (cnt == '0) begin
                    cnt <= CW'(1);
                end
            end else if (push_i) begin
                tp          <= tp_inc;
                mem[tp_inc] <= data_i;
                if (cnt == CNT_FULL) begin
                    // tp+1 is the oldest slot when full, so it is overwritten.
                    overflow <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else if (pop_i) begin
                if (cnt == '0) begin
                    underflow <= 1'b1;
                end else begin
                    tp  <= tp_dec;
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end

    assign data_o      = (cnt != '0) ? mem[tp] : '0;
    assign valid_o     = (cnt != '0);
    assign count_o     = cnt;
    assign overflow_o  = overflow;
    assign underflow_o = underflow;

endmodule
